// File: rtl/ioctl_sdram_sequencer.sv
// Sequences SDRAM port1 for data_io: ROM/NVRAM download writes, NVRAM upload reads.
// One toggle req/ack transaction in flight, one buffered write, CMOS address remap.
module ioctl_sdram_sequencer #(
  parameter int              AW          = 23,
  parameter logic [AW-1:0]   CMOS_BASE   = 'h1CC00,
  parameter logic [7:0]      CMOS_INDEX  = 8'hFF,
  parameter logic [12:0]     ROM_CMOS_HI = 13'h0034,
  parameter int              TIMEOUT     = 255
) (
  input  logic          clk_mem,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic          ioctl_upl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          port1_req,
  input  logic          port1_ack,
  output logic [AW-1:0] port1_a,
  output logic          port1_we,
  output logic [15:0]   port1_d,
  input  logic [15:0]   port1_q,
  output logic          pause,
  output logic          busy,
  output logic          err_ovf,
  output logic          err_tmo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t state, state_nx;

  logic          wr_q, upl_q, resync;
  logic [9:0]    addr_q;
  logic          buf_v;
  logic [AW-1:0] buf_a, rd_a;
  logic [7:0]    buf_d;
  logic          rd_pend;
  logic [TW-1:0] timer;

  logic          is_cmos, wr_edge, rd_trig, ack_ok;
  logic          issue_wr, issue_rd, tmo, waiting;
  logic [AW-1:0] map_a;
  logic          unused;

  assign unused = ^{ioctl_addr, port1_q};

  assign is_cmos = (ioctl_index == CMOS_INDEX) ||
                   (ioctl_index == 8'd0 &&
                    ioctl_addr[22:10] == ROM_CMOS_HI);
  assign map_a   = is_cmos ? (CMOS_BASE | AW'(ioctl_addr[9:0]))
                           : ioctl_addr[AW-1:0];
  assign wr_edge = ioctl_downl & ioctl_wr & ~wr_q;
  assign rd_trig = ioctl_upl &
                   (~upl_q | (ioctl_addr[9:0] != addr_q));
  assign ack_ok  = (port1_ack == port1_req);

  always_ff @(posedge clk_mem) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (issue_wr)      state_nx = WR_WAIT;
        else if (issue_rd) state_nx = RD_WAIT;
      end
      WR_WAIT, RD_WAIT: begin
        if (ack_ok || tmo) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    waiting  = (state == WR_WAIT) || (state == RD_WAIT);
    issue_wr = (state == IDLE) && !resync && buf_v;
    issue_rd = (state == IDLE) && !resync && !buf_v &&
               rd_pend && ioctl_upl;
    tmo      = waiting && !ack_ok && (timer == TW'(TIMEOUT - 1));
    busy     = (state != IDLE);
    pause    = ioctl_upl || (state == RD_WAIT);
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_we  <= 1'b0;
      port1_d   <= '0;
      ioctl_din <= '0;
      buf_v     <= 1'b0;
      buf_a     <= '0;
      buf_d     <= '0;
      rd_pend   <= 1'b0;
      rd_a      <= '0;
      err_ovf   <= 1'b0;
      err_tmo   <= 1'b0;
      timer     <= '0;
      resync    <= 1'b1;
      wr_q      <= 1'b0;
      upl_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      wr_q   <= ioctl_wr;
      upl_q  <= ioctl_upl;
      addr_q <= ioctl_addr[9:0];
      resync <= 1'b0;
      // First cycle out of reset: adopt ack so the next request is a real toggle
      if (resync) port1_req <= port1_ack;

      if (issue_wr) begin
        port1_a   <= buf_a;
        port1_we  <= 1'b1;
        port1_d   <= {{2{buf_d[7:4]}}, {2{buf_d[3:0]}}};
        port1_req <= ~port1_req;
        timer     <= '0;
        buf_v     <= 1'b0;
      end else if (issue_rd) begin
        port1_a   <= rd_a;
        port1_we  <= 1'b0;
        port1_req <= ~port1_req;
        timer     <= '0;
      end

      if (wr_edge) begin
        if (!buf_v || issue_wr) begin
          buf_v <= 1'b1;
          buf_a <= map_a;
          buf_d <= ioctl_dout;
        end else begin
          err_ovf <= 1'b1;
        end
      end

      if (!ioctl_upl) begin
        rd_pend <= 1'b0;
      end else if (rd_trig) begin
        rd_pend <= 1'b1;
        rd_a    <= map_a;
      end else if (issue_rd) begin
        rd_pend <= 1'b0;
      end

      if (waiting) begin
        if (ack_ok) begin
          if (state == RD_WAIT)
            ioctl_din <= {port1_q[11:8], port1_q[3:0]};
        end else if (tmo) begin
          err_tmo   <= 1'b1;
          port1_req <= port1_ack;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ioctl_sdram_sequencer.sv
// Directed bench for ioctl_sdram_sequencer with a latency-programmable
// toggle ack responder.
module tb_ioctl_sdram_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_downl, ioctl_upl, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
  logic [24:0] ioctl_addr;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [15:0] port1_d, port1_q;
  logic        pause, busy, err_ovf, err_tmo;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int toggles = 0;
  logic req_prev = 1'b0;
  logic ack_en;
  int ack_lat;

  ioctl_sdram_sequencer dut (
    .clk_mem(clk), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_upl(ioctl_upl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .port1_req(port1_req),
    .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_we(port1_we), .port1_d(port1_d),
    .port1_q(port1_q), .pause(pause), .busy(busy),
    .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (port1_req !== req_prev) toggles++;
    req_prev = port1_req;
  end

  initial forever begin
    @(negedge clk);
    if (ack_en && port1_req !== port1_ack) begin
      repeat (ack_lat) @(posedge clk);
      #1 port1_ack = port1_req;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag, input logic v);
    int n = 0;
    while (busy !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'(v));
  endtask

  task automatic do_write(input logic [7:0] idx,
                          input logic [24:0] adr,
                          input logic [7:0] dat);
    @(posedge clk);
    #1;
    ioctl_downl = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = adr;
    ioctl_dout  = dat;
    ioctl_wr    = 1'b1;
    tick(2);
    ioctl_wr = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, t0;
    reset = 1'b1;
    ioctl_downl = 0; ioctl_upl = 0; ioctl_wr = 0;
    ioctl_index = 0; ioctl_addr = 0; ioctl_dout = 0;
    port1_ack = 0; port1_q = 16'h0F0A;
    ack_en = 1'b1; ack_lat = 2;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_req", 32'(port1_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a", 32'(port1_a), 0);
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_ovf", 32'(err_ovf), 0);
    chk("rst_tmo", 32'(err_tmo), 0);
    chk("rst_pause", 32'(pause), 0);

    b0 = busy_cnt; t0 = toggles;
    do_write(8'h00, 25'h0100, 8'hA5);
    chk("w1_a", 32'(port1_a), 32'h0100);
    chk("w1_we", 32'(port1_we), 1);
    chk("w1_d", 32'(port1_d), 32'hAA55);
    wait_busy("w1_idle", 1'b0);
    chk("w1_busy_cycles", 32'(busy_cnt - b0), 3);
    chk("w1_toggles", 32'(toggles - t0), 1);

    do_write(8'h00, 25'h0D005, 8'h3C);
    chk("w2_a_rom_cmos", 32'(port1_a), 32'h1CC05);
    chk("w2_d", 32'(port1_d), 32'h33CC);
    wait_busy("w2_idle", 1'b0);
    do_write(8'hFF, 25'h003FF, 8'h11);
    chk("w3_a_cmos", 32'(port1_a), 32'h1CFFF);
    wait_busy("w3_idle", 1'b0);
    ioctl_downl = 1'b0;

    t0 = toggles;
    ioctl_index = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) port1_q = 16'h1234;
      ioctl_addr = 25'(k);
      ioctl_upl  = 1'b1;
      wait_busy($sformatf("r%0d_start", k), 1'b1);
      chk($sformatf("r%0d_a", k), 32'(port1_a), 32'h1CC00 + k);
      chk($sformatf("r%0d_we", k), 32'(port1_we), 0);
      chk($sformatf("r%0d_pause", k), 32'(pause), 1);
      wait_busy($sformatf("r%0d_idle", k), 1'b0);
      chk($sformatf("r%0d_din", k), 32'(ioctl_din),
          (k == 3) ? 32'h24 : 32'hFA);
    end
    chk("r_toggles", 32'(toggles - t0), 4);
    ioctl_upl = 1'b0;
    tick(1);
    chk("upl_end_pause", 32'(pause), 0);

    ack_lat = 20;
    t0 = toggles;
    @(posedge clk);
    #1;
    ioctl_downl = 1'b1; ioctl_index = 8'h00;
    ioctl_addr = 25'h0200;
    for (int k = 0; k < 3; k++) begin
      ioctl_dout = 8'h12 + 8'(k * 8'h22);
      ioctl_wr = 1'b1;
      tick(2);
      ioctl_wr = 1'b0;
      tick(2);
    end
    chk("ovf_flag", 32'(err_ovf), 1);
    tick(60);
    chk("ovf_busy", 32'(busy), 0);
    chk("ovf_toggles", 32'(toggles - t0), 2);
    chk("ovf_last_d", 32'(port1_d), 32'h3344);
    ioctl_downl = 1'b0;
    ack_lat = 2;

    ack_en = 1'b0;
    do_write(8'h00, 25'h0300, 8'h77);
    ioctl_downl = 1'b0;
    tick(240);
    chk("tmo_early", 32'(err_tmo), 0);
    chk("tmo_early_busy", 32'(busy), 1);
    tick(30);
    chk("tmo_flag", 32'(err_tmo), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_req_ack", 32'(port1_req), 32'(port1_ack));

    ioctl_index = 8'hFF;
    ioctl_addr  = 25'h005;
    ioctl_upl   = 1'b1;
    wait_busy("rr_start", 1'b1);
    chk("rr_pause", 32'(pause), 1);
    @(negedge clk);
    reset = 1'b1;
    ioctl_upl = 1'b0;
    tick(1);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_pause_off", 32'(pause), 0);
    chk("rr_req", 32'(port1_req), 0);
    chk("rr_tmo_clr", 32'(err_tmo), 0);
    chk("rr_ovf_clr", 32'(err_ovf), 0);
    reset = 1'b0;
    tick(1);
    chk("rr_resync", 32'(port1_req), 32'(port1_ack));
    chk("rr_resync_one", 32'(port1_req), 1);
    ioctl_upl = 1'b1;
    #1;
    chk("rr_pause_upl", 32'(pause), 1);
    ack_en = 1'b1;
    tick(10);
    chk("rr_read_busy", 32'(busy), 0);
    chk("rr_read_din", 32'(ioctl_din), 32'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
